// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_FETCH      = 2'd1,
        ST_HOLD       = 2'd2,
        ST_REDIR_PEND = 2'd3
    } pc_state_t;

    // Redirect sources, ordered so a larger code wins
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_JMP  = 2'd1,
        RD_BR   = 2'd2,
        RD_EXC  = 2'd3
    } redir_src_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/redirect_sel.sv
// rtl/redirect_sel.sv - priority mux selecting the redirect source and its target
module redirect_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        redirect,
    output logic [31:0] target,
    output redir_src_t  src
);

    always_comb begin
        redirect = 1'b0;
        target   = 32'h0000_0000;
        src      = RD_NONE;
        if (exc) begin
            redirect = 1'b1;
            target   = word_align(EXC_VECTOR);
            src      = RD_EXC;
        end else if (br_taken) begin
            redirect = 1'b1;
            target   = word_align(br_target);
            src      = RD_BR;
        end else if (jmp) begin
            redirect = 1'b1;
            target   = word_align(jmp_target);
            src      = RD_JMP;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection and instruction fetch handshake control
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        if_valid,
    output logic        flush
);

    pc_state_t   state, state_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic        pend_exc, pend_exc_nxt;

    logic        redirect;
    logic [31:0] redir_target;
    redir_src_t  redir_src;
    logic [31:0] pc_seq;
    logic        take_new;

    redirect_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .exc        (exc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .redirect   (redirect),
        .target     (redir_target),
        .src        (redir_src)
    );

    assign pc_seq = pc_cur + INSTR_BYTES;

    // Falling edge matches the PC register so pc_next is consumed the same edge
    always_ff @(negedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pend_target <= 32'h0000_0000;
            pend_exc    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            pend_exc    <= pend_exc_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pend_exc_nxt    = pend_exc;
        pc_next         = pc_cur;
        imem_req        = 1'b0;
        if_valid        = 1'b0;
        flush           = 1'b0;
        take_new        = 1'b0;

        if (reset) begin
            pc_next = RESET_VECTOR;
        end else begin
            case (state)
                ST_BOOT: begin
                    pc_next   = RESET_VECTOR;
                    state_nxt = ST_FETCH;
                end

                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        flush = 1'b1;
                        if (imem_ready) begin
                            pc_next = redir_target;
                        end else begin
                            pend_target_nxt = redir_target;
                            pend_exc_nxt    = (redir_src == RD_EXC);
                            state_nxt       = ST_REDIR_PEND;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            if_valid = 1'b1;
                            pc_next  = pc_seq;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        flush     = 1'b1;
                        pc_next   = redir_target;
                        state_nxt = ST_FETCH;
                    end else if (!stall) begin
                        if_valid  = 1'b1;
                        pc_next   = pc_seq;
                        state_nxt = ST_FETCH;
                    end
                end

                ST_REDIR_PEND: begin
                    imem_req = 1'b1;
                    flush    = redirect;
                    // A pending exception can only be displaced by another exception
                    take_new = redirect && (!pend_exc || redir_src == RD_EXC);
                    if (take_new) begin
                        pend_target_nxt = redir_target;
                        pend_exc_nxt    = (redir_src == RD_EXC);
                    end
                    if (imem_ready) begin
                        pc_next      = take_new ? redir_target : pend_target;
                        pend_exc_nxt = 1'b0;
                        state_nxt    = ST_FETCH;
                    end
                end

                default: begin
                    state_nxt = ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] pc_next;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        imem_req;
    logic        imem_ready;
    logic        if_valid;
    logic        flush;

    logic        pc_load;
    logic [31:0] pc_load_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        req;
        logic        val;
        logic        fl;
        logic        fl_chk;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .exc        (exc),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .if_valid   (if_valid),
        .flush      (flush)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Model of the external PC register, with a preload hook for directed starts
    always @(negedge clk) begin
        if (pc_load) pc_cur <= pc_load_val;
        else         pc_cur <= pc_next;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".pc_next"},  pc_next,  e.pc);
            check({e.tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, e.req});
            check({e.tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, e.val});
            if (e.fl_chk) check({e.tag, ".flush"}, {31'b0, flush}, {31'b0, e.fl});
            check({e.tag, ".excl"}, {31'b0, flush & if_valid}, 32'h0);
        end
    end

    task automatic step(input string tag, input logic r, input logic s, input logic rdy,
                        input logic e, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic [31:0] x_pc, input logic x_req, input logic x_val,
                        input logic x_fl, input logic x_flchk);
        exp_t x;
        @(negedge clk);
        #1;
        pc_load    = 1'b0;
        reset      = r;
        stall      = s;
        imem_ready = rdy;
        exc        = e;
        br_taken   = b;
        br_target  = bt;
        jmp        = j;
        jmp_target = jt;
        x.tag    = tag;
        x.pc     = x_pc;
        x.req    = x_req;
        x.val    = x_val;
        x.fl     = x_fl;
        x.fl_chk = x_flchk;
        sb.push_back(x);
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; exc = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; jmp = 1'b0; jmp_target = 32'h0;
        pc_load = 1'b0; pc_load_val = 32'h0;

        //    tag         r  s  rdy e  b  btgt          j  jtgt          pc_next       req val fl chk
        step("rst0",      1, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("rst1",      1, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("boot",      0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("seq4",      0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1, 0, 1);
        step("seq8",      0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 1, 0, 1);
        step("seq12",     0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 1, 0, 1);
        step("seq16",     0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 1, 0, 1);
        // stall at 0x10
        step("stall_f",   0, 1, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 0, 1);
        step("hold1",     0, 1, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 0, 0, 0, 1);
        step("hold2",     0, 1, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 0, 0, 0, 1);
        step("hold_rel",  0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 0, 1, 0, 1);
        // taken branch with ready, target low bits dropped
        step("br_rdy",    0, 0, 1,  0, 1, 32'h0000_0203, 0, 32'h0,       32'h0000_0200, 1, 0, 1, 1);
        step("wait",      0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 0, 1);
        // pending redirect overwritten by a branch
        step("jmp_nrdy",  0, 0, 0,  0, 0, 32'h0,        1, 32'h0000_0400, 32'h0000_0200, 1, 0, 1, 1);
        step("br_pend",   0, 1, 0,  0, 1, 32'h0000_0300, 0, 32'h0,       32'h0000_0200, 1, 0, 1, 1);
        step("pend_w1",   0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 0, 1);
        step("pend_w2",   0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 0, 1);
        step("pend_rdy",  0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0300, 1, 0, 0, 1);
        // exception beats branch; pending exception survives a jump
        step("exc_br",    0, 0, 1,  1, 1, 32'h0000_0500, 0, 32'h0,       32'h0000_0080, 1, 0, 1, 1);
        step("seq84",     0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0084, 1, 1, 0, 1);
        step("exc_nrdy",  0, 0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0000_0084, 1, 0, 1, 1);
        step("jmp_vs_ex", 0, 0, 0,  0, 0, 32'h0,        1, 32'h0000_0600, 32'h0000_0084, 1, 0, 0, 0);
        step("exc_land",  0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 0, 0, 1);
        // redirect in HOLD wins over stall release
        step("stall_80",  0, 1, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 0, 0, 1);
        step("hold_jmp",  0, 0, 1,  0, 0, 32'h0,        1, 32'h0000_1001, 32'h0000_1000, 0, 0, 1, 1);
        step("seq1004",   0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_1004, 1, 1, 0, 1);
        // wrap of the sequential increment
        load_pc(32'hFFFF_FFFC);
        step("wrap",      0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1, 0, 1);
        step("seq_w4",    0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1, 0, 1);
        // reset while a redirect is pending
        step("jmp_pend",  0, 0, 0,  0, 0, 32'h0,        1, 32'h0000_0700, 32'h0000_0004, 1, 0, 1, 1);
        step("rst_pend",  1, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("boot2",     0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 1);
        step("seq_r4",    0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1, 0, 1);

        repeat (2) @(negedge clk);
        check("sb_drain", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, 32'h0000_0000, address loaded after reset.
REQ-002 SHALL have parameter EXC_VECTOR, 32'h0000_0080, exception handler address.
REQ-003 SHALL have port clk, input, 1, clock; all state updates occur on the falling edge, the same edge as the PC register.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port pc_cur, input, 32, current PC register output.
REQ-006 SHALL have port pc_next, output, 32, drives the PC register data input; it is captured every falling edge.
REQ-007 SHALL have ports stall, input, 1, hazard-unit freeze of IF.
REQ-008 SHALL have ports br_taken (input, 1) and br_target (input, 32): resolved taken branch.
REQ-009 SHALL have ports jmp (input, 1) and jmp_target (input, 32): jump.
REQ-010 SHALL have port exc, input, 1, exception request.
REQ-011 SHALL have ports imem_req (output, 1) and imem_ready (input, 1): instruction-memory handshake; address = pc_cur.
REQ-012 SHALL have port if_valid, output, 1, fetched instruction valid for IF/ID this cycle.
REQ-013 SHALL have port flush, output, 1, one-cycle kill of IF/ID on redirect.

Function
REQ-014 SHALL implement states BOOT, FETCH, HOLD, REDIR_PEND.
REQ-015 Outputs SHALL be combinational from state and inputs; state and pend_target SHALL be registered.
REQ-016 Redirect priority SHALL be exc (EXC_VECTOR) > br_taken (br_target) > jmp (jmp_target); the selected target has bits[1:0] forced to 00.
REQ-017 BOOT SHALL output pc_next=RESET_VECTOR, imem_req=0, if_valid=0, flush=0, and then go to FETCH.
REQ-018 FETCH SHALL output imem_req=1.
REQ-019 FETCH with redirect and imem_ready SHALL output pc_next=target, flush=1, if_valid=0, and stay in FETCH.
REQ-020 FETCH with redirect and !imem_ready SHALL latch target into pend_target, output flush=1, pc_next=pc_cur, and go to REDIR_PEND.
REQ-021 FETCH with imem_ready & !stall and no redirect SHALL output if_valid=1 and pc_next=pc_cur+4.
REQ-022 FETCH with imem_ready & stall SHALL output pc_next=pc_cur, if_valid=0, and go to HOLD.
REQ-023 FETCH with !imem_ready SHALL output pc_next=pc_cur.
REQ-024 HOLD SHALL output imem_req=0 and pc_next=pc_cur while stall=1.
REQ-025 HOLD with stall=0 SHALL output if_valid=1, pc_next=pc_cur+4, and go to FETCH.
REQ-026 HOLD with redirect SHALL output pc_next=target, flush=1, if_valid=0, and go to FETCH; redirect beats a stall release.
REQ-027 REDIR_PEND SHALL output imem_req=1, pc_next=pc_cur, and if_valid=0.
REQ-028 REDIR_PEND on imem_ready SHALL discard the data, output pc_next=pend_target, and go to FETCH.
REQ-029 A new redirect in REDIR_PEND SHALL overwrite pend_target and assert flush, unless the pending one is exc; a pending exc SHALL be overwritten only by exc.
REQ-030 While imem_req=1 and imem_ready=0, pc_next SHALL equal pc_cur (address stable).
REQ-031 pc_cur+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-032 stall SHALL never suppress a redirect; if_valid and flush SHALL never both be 1.

Reset
REQ-033 While reset=1, outputs SHALL be pc_next=RESET_VECTOR, imem_req=0, if_valid=0, flush=0.
REQ-034 On a falling edge with reset=1, the next state SHALL be BOOT and pend_target SHALL clear to 0.
REQ-035 Reset asserted in any state, including REDIR_PEND, SHALL abandon the outstanding fetch and pending redirect.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state encoding, INSTR_BYTES=4, and the redirect-priority encoding.
REQ-037 Sub-module redirect_sel SHALL hold the combinational priority mux producing redirect and target.

Verification
REQ-038 Reset sequence: reset 2 cycles, release, imem_ready=1 -> pc_next 0, 0, then 4, 8, 12 with if_valid=1 from the 3rd cycle.
REQ-039 Stall: pc_cur=0x10, imem_ready=1, stall=1 for 3 cycles -> pc_next=0x10, state HOLD, if_valid=0; stall drops -> pc_next=0x14, if_valid=1.
REQ-040 Branch with ready: br_taken=1, br_target=0x203, imem_ready=1 in FETCH -> pc_next=0x200, flush=1.
REQ-041 Pending redirect: jmp to 0x400 with imem_ready=0, then br_taken to 0x300 next cycle, ready after 2 more cycles -> pc_next stays at pc_cur until ready, then 0x300, if_valid=0.
REQ-042 Exception priority: exc=1 with br_taken=1 -> target 0x80; exc pending and later jmp -> still 0x80.
REQ-043 Wrap and reset mid-op: pc_cur=0xFFFF_FFFC, ready -> pc_next=0; reset asserted in REDIR_PEND -> pc_next=0, imem_req=0 next cycle.
